// File: rtl/ysyx_22041461_opfetch.sv
// Operand-fetch stage: drives register-file reads, tracks in-flight destinations in a
// 32-entry busy scoreboard, bypasses same-cycle writeback and holds one issued instruction.
module ysyx_22041461_opfetch #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic             in_rd_wen,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [4:0]       out_rd,
    output logic             out_rd_wen,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0]      busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
    logic [XLEN-1:0]  out_rs2_q, out_rs2_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic             out_rd_wen_q, out_rd_wen_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             wbHit1, wbHit2;
    logic             hazard1, hazard2;
    logic             issue;
    logic [XLEN-1:0]  rs1Value, rs2Value;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    assign wbHit1  = wb_valid && (wb_rd == in_rs1);
    assign wbHit2  = wb_valid && (wb_rd == in_rs2);
    assign hazard1 = in_use_rs1 && (in_rs1 != 5'd0) && busy_q[in_rs1] && !wbHit1;
    assign hazard2 = in_use_rs2 && (in_rs2 != 5'd0) && busy_q[in_rs2] && !wbHit2;

    // out_ready gates acceptance only; held data never depends on it combinationally.
    assign in_ready = !flush && !hazard1 && !hazard2 && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    assign rs1Value = (in_rs1 == 5'd0) ? '0 : (wbHit1 ? wb_data : rf_rs1_data);
    assign rs2Value = (in_rs2 == 5'd0) ? '0 : (wbHit2 ? wb_data : rf_rs2_data);

    always_comb begin
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_rd_d     = out_rd_q;
        out_rd_wen_d = out_rd_wen_q;
        stall_d      = stall_q;

        // Clear first so that a same-index set in this cycle wins.
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue && in_rd_wen && (in_rd != 5'd0)) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (issue) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_rs1_d    = rs1Value;
            out_rs2_d    = rs2Value;
            out_rd_d     = in_rd;
            out_rd_wen_d = in_rd_wen;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
        end

        if (in_valid && !flush && (hazard1 || hazard2) && (stall_q != '1)) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_rd_q     <= out_rd_d;
            out_rd_wen_q <= out_rd_wen_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_ysyx_22041461_opfetch.sv
// Directed bench for the operand-fetch stage: expected issues go into a queue and a
// monitor checks each retired entry; hazards, stalls, flush and reset are checked inline.
module tb_ysyx_22041461_opfetch;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [4:0]      rd;
        logic            wen;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic             in_use_rs1, in_use_rs2, in_rd_wen;
    logic [4:0]       rf_rs1, rf_rs2;
    logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc, out_rs1_data, out_rs2_data;
    logic [4:0]       out_rd;
    logic             out_rd_wen;
    logic [CNT_W-1:0] stall_cnt;

    exp_t expQ[$];
    int   compareCount = 0;
    int   failCount    = 0;

    ysyx_22041461_opfetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_use_rs1   (in_use_rs1),
        .in_use_rs2   (in_use_rs2),
        .in_rd_wen    (in_rd_wen),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_rd       (out_rd),
        .out_rd_wen   (out_rd_wen),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic u1, input logic u2, input logic wen,
                                 input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_use_rs1  = u1;
        in_use_rs2  = u2;
        in_rd_wen   = wen;
        rf_rs1_data = d1;
        rf_rs2_data = d2;
    endtask

    task automatic expectIssue(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] r1,
                               input logic [XLEN-1:0] r2, input logic [4:0] rd, input logic wen);
        exp_t e;
        e.pc  = pc;
        e.r1  = r1;
        e.r2  = r2;
        e.rd  = rd;
        e.wen = wen;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each retiring entry is compared against the oldest expected issue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_retire_pc", out_pc, '1);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("retire_pc", out_pc, e.pc);
                checkOutput("retire_rs1_data", out_rs1_data, e.r1);
                checkOutput("retire_rs2_data", out_rs2_data, e.r2);
                checkOutput("retire_rd_wen", {58'd0, out_rd, out_rd_wen}, {58'd0, e.rd, e.wen});
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd_wen = 1'b0;
        rf_rs1_data = '0; rf_rs2_data = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b0;
        #12;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_pc", out_pc, 64'd0);
        checkOutput("reset_out_rs1", out_rs1_data, 64'd0);
        checkOutput("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        rst = 1'b1;
        step();

        // Basic issue with both sources from the register file
        applyStimulus(64'h100, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 64'h11, 64'h22);
        #1 checkOutput("basic_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rf_rs1_addr", {59'd0, rf_rs1}, 64'd5);
        expectIssue(64'h100, 64'h11, 64'h22, 5'd7, 1'b1);
        step();
        checkOutput("basic_out_valid", {63'd0, out_valid}, 64'd1);

        // RAW on x7: stall until writeback, then bypass
        applyStimulus(64'h104, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 64'h5555, 64'h0);
        #1 checkOutput("raw_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("raw_stall_1", {32'd0, stall_cnt}, 64'd1);
        step();
        checkOutput("raw_stall_2", {32'd0, stall_cnt}, 64'd2);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'hABCD;
        #1 checkOutput("raw_wb_in_ready", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h104, 64'hABCD, 64'h0, 5'd8, 1'b1);
        step();
        wb_valid = 1'b0;
        checkOutput("raw_stall_hold", {32'd0, stall_cnt}, 64'd2);

        // x7 now free; x8 busy but rs2 unused so no hazard; rd=0 write never marks busy
        applyStimulus(64'h108, 5'd7, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 64'h77, 64'h88);
        #1 checkOutput("unused_src_in_ready", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h108, 64'h77, 64'h88, 5'd0, 1'b1);
        step();

        applyStimulus(64'h10C, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'hFFFF, 64'hFFFF);
        #1 checkOutput("x0_in_ready", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h10C, 64'h0, 64'h0, 5'd0, 1'b0);
        step();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 64'h8;
        step();
        wb_valid = 1'b0;

        // Backpressure: hold, then reload with no bubble
        out_ready = 1'b0;
        applyStimulus(64'h110, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 1'b1, 64'h1010, 64'h2020);
        expectIssue(64'h110, 64'h1010, 64'h2020, 5'd10, 1'b1);
        step();
        applyStimulus(64'h114, 5'd3, 5'd4, 5'd11, 1'b1, 1'b1, 1'b1, 64'h3030, 64'h4040);
        #1 checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        step();
        checkOutput("bp_hold_pc", out_pc, 64'h110);
        checkOutput("bp_hold_rs1", out_rs1_data, 64'h1010);
        out_ready = 1'b1;
        #1 checkOutput("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h114, 64'h3030, 64'h4040, 5'd11, 1'b1);
        step();
        in_valid = 1'b0;
        checkOutput("bp_no_bubble_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("bp_no_bubble_pc", out_pc, 64'h114);
        checkOutput("bp_stall_cnt", {32'd0, stall_cnt}, 64'd2);

        // Same-index writeback and issue: set wins
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h1;
        applyStimulus(64'h118, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
        expectIssue(64'h118, 64'h0, 64'h0, 5'd9, 1'b1);
        step();
        wb_valid = 1'b0;
        applyStimulus(64'h11C, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 64'h5, 64'h6);
        #1 checkOutput("same_idx_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("same_idx_stall", {32'd0, stall_cnt}, 64'd3);
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        expectIssue(64'h11C, 64'h99, 64'h0, 5'd0, 1'b0);
        step();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        step();

        // Flush with x3 busy and a held entry
        out_ready = 1'b0;
        applyStimulus(64'h120, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
        step();
        checkOutput("flush_pre_valid", {63'd0, out_valid}, 64'd1);
        applyStimulus(64'h124, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 64'h3333, 64'h0);
        flush = 1'b1;
        #1 checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        flush = 1'b0;
        checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("flush_stall_cnt", {32'd0, stall_cnt}, 64'd3);
        #1 checkOutput("flush_consumer_ready", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h124, 64'h3333, 64'h0, 5'd12, 1'b1);
        out_ready = 1'b1;
        step();
        applyStimulus(64'h128, 5'd10, 5'd11, 5'd0, 1'b1, 1'b1, 1'b0, 64'hA, 64'hB);
        #1 checkOutput("flush_cleared_all", {63'd0, in_ready}, 64'd1);
        expectIssue(64'h128, 64'hA, 64'hB, 5'd0, 1'b0);
        step();

        // Reset asserted mid-stall
        applyStimulus(64'h130, 5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
        expectIssue(64'h130, 64'h0, 64'h0, 5'd13, 1'b1);
        step();
        applyStimulus(64'h134, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 64'h1313, 64'h0);
        #1 checkOutput("rst_stall_ready", {63'd0, in_ready}, 64'd0);
        step();
        checkOutput("rst_stall_cnt", {32'd0, stall_cnt}, 64'd4);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_mid_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        checkOutput("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        rst = 1'b1;
        expectIssue(64'h134, 64'h1313, 64'h0, 5'd0, 1'b0);
        step();
        in_valid = 1'b0;

        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            step();
        end
        checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
